// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the fifo write-port arbiter.
// The state encoding and clog2 helper are used by the arbiter top and its parameter defaults.
package fifo_arb_pkg;

   typedef enum logic {
      ARB   = 1'b0,
      GRANT = 1'b1
   } arb_state_e;

   localparam int DEFAULT_BURST_LEN = 8;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int v = value - 1; v > 0; v = v >> 1) begin
         result++;
      end
      return result;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: the first requester at or after last_id+1 (wrapping) wins.
// any is low when no request bit is set, in which case next_id simply echoes last_id.
module rr_pick #(
   parameter int NUM_REQ  = 4,
   parameter int ID_WIDTH = 2
) (
   input  logic [NUM_REQ-1:0]  req,
   input  logic [ID_WIDTH-1:0] last_id,
   output logic [ID_WIDTH-1:0] next_id,
   output logic                any
);

   always_comb begin
      int idx;
      logic [ID_WIDTH-1:0] sel;
      next_id = last_id;
      any     = 1'b0;
      idx     = 0;
      sel     = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = (int'(last_id) + k) % NUM_REQ;
         sel = ID_WIDTH'(idx);
         if (!any && req[sel]) begin
            any     = 1'b1;
            next_id = sel;
         end
      end
   end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Shares the clock-crossing fifo write port among NUM_REQ producers with round-robin,
// burst-bounded, packet-aware grants and a single registered output stage.
module fifo_write_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 32,
   parameter int BURST_LEN  = DEFAULT_BURST_LEN,
   parameter int ID_WIDTH   = clog2(NUM_REQ)
) (
   input  logic                          clock_in,
   input  logic                          rst_in_n,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   input  logic [NUM_REQ-1:0]            req_last,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic [DATA_WIDTH-1:0]         data_in,
   output logic                          data_in_valid,
   input  logic                          data_in_full,
   output logic [ID_WIDTH-1:0]           grant_id,
   output logic                          grant_active
);

   localparam int CNT_WIDTH = clog2(BURST_LEN + 1);

   arb_state_e           state;
   logic [CNT_WIDTH-1:0] burst_cnt;
   logic [DATA_WIDTH-1:0] req_word [NUM_REQ];
   logic [ID_WIDTH-1:0]  pick_id;
   logic                 pick_any;
   logic                 can_take;
   logic                 sel_valid;
   logic                 sel_last;
   logic                 accept;
   logic                 burst_done;

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_word
      assign req_word[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
   end

   rr_pick #(
      .NUM_REQ  (NUM_REQ),
      .ID_WIDTH (ID_WIDTH)
   ) u_pick (
      .req     (req_valid),
      .last_id (grant_id),
      .next_id (pick_id),
      .any     (pick_any)
   );

   // The output register can take a word if it is empty or draining into the fifo this edge.
   assign can_take     = !data_in_valid || !data_in_full;
   assign sel_valid    = req_valid[grant_id];
   assign sel_last     = req_last[grant_id];
   assign accept       = (state == GRANT) && can_take && sel_valid;
   assign burst_done   = (burst_cnt == CNT_WIDTH'(BURST_LEN - 1));
   assign grant_active = (state == GRANT);

   always_comb begin
      req_ready = '0;
      if (state == GRANT && can_take) begin
         req_ready[grant_id] = 1'b1;
      end
   end

   // grant_id doubles as the round-robin pointer, so it is only updated when a new grant is made.
   always_ff @(posedge clock_in or negedge rst_in_n) begin
      if (!rst_in_n) begin
         state         <= ARB;
         grant_id      <= ID_WIDTH'(NUM_REQ - 1);
         burst_cnt     <= '0;
         data_in       <= '0;
         data_in_valid <= 1'b0;
      end else begin
         if (accept) begin
            data_in       <= req_word[grant_id];
            data_in_valid <= 1'b1;
            burst_cnt     <= burst_cnt + 1'b1;
         end else if (data_in_valid && !data_in_full) begin
            data_in_valid <= 1'b0;
         end

         case (state)
            ARB: begin
               if (pick_any) begin
                  grant_id  <= pick_id;
                  burst_cnt <= '0;
                  state     <= GRANT;
               end
            end
            GRANT: begin
               if (accept && (sel_last || burst_done)) begin
                  state <= ARB;
               end else if (can_take && !sel_valid) begin
                  state <= ARB;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter: producer queues feed the requesters and a monitor
// compares every fifo write against a queue of hand-ordered expected words.
module tb_fifo_write_arbiter;

   localparam int NUM_REQ    = 4;
   localparam int DATA_WIDTH = 32;
   localparam int ID_WIDTH   = 2;

   typedef struct packed {
      logic [DATA_WIDTH-1:0] data;
      logic                  last;
   } word_t;

   logic                          clock_in = 1'b0;
   logic                          rst_in_n;
   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]            req_last;
   logic [NUM_REQ-1:0]            req_ready;
   logic [DATA_WIDTH-1:0]         data_in;
   logic                          data_in_valid;
   logic                          data_in_full;
   logic [ID_WIDTH-1:0]           grant_id;
   logic                          grant_active;

   word_t                 src_q [NUM_REQ][$];
   logic [DATA_WIDTH-1:0] exp_q [$];
   int                    stamps [$];
   int                    rise_cyc [NUM_REQ];
   int                    checks = 0;
   int                    passed = 0;
   int                    cyc = 0;
   int                    write_count = 0;

   fifo_write_arbiter #(
      .NUM_REQ    (NUM_REQ),
      .DATA_WIDTH (DATA_WIDTH),
      .BURST_LEN  (8),
      .ID_WIDTH   (ID_WIDTH)
   ) dut (
      .clock_in      (clock_in),
      .rst_in_n      (rst_in_n),
      .req_valid     (req_valid),
      .req_data      (req_data),
      .req_last      (req_last),
      .req_ready     (req_ready),
      .data_in       (data_in),
      .data_in_valid (data_in_valid),
      .data_in_full  (data_in_full),
      .grant_id      (grant_id),
      .grant_active  (grant_active)
   );

   always #5 clock_in = ~clock_in;

   always @(posedge clock_in) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual === expected) passed++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
   endtask

   function automatic logic [DATA_WIDTH-1:0] word(input int tst, input int id, input int seq);
      logic [7:0]  t8;
      logic [7:0]  i8;
      logic [15:0] s16;
      t8  = 8'(tst);
      i8  = 8'(id);
      s16 = 16'(seq);
      return {t8, i8, s16};
   endfunction

   // Queue n words for requester id; last_idx < 0 means the packet never ends.
   task automatic applyStimulus(input int id, input int tst, input int n, input int last_idx);
      word_t w;
      for (int s = 0; s < n; s++) begin
         w.data = word(tst, id, s);
         w.last = (s == last_idx);
         src_q[id].push_back(w);
      end
   endtask

   task automatic expectWords(input int id, input int tst, input int first, input int last);
      for (int s = first; s <= last; s++) exp_q.push_back(word(tst, id, s));
   endtask

   task automatic clearQueues();
      for (int i = 0; i < NUM_REQ; i++) src_q[i].delete();
      exp_q.delete();
      stamps.delete();
   endtask

   task automatic doReset();
      @(negedge clock_in);
      rst_in_n     = 1'b0;
      data_in_full = 1'b0;
      @(posedge clock_in); #2;
      clearQueues();
      @(posedge clock_in); #2;
      @(negedge clock_in);
      rst_in_n = 1'b1;
   endtask

   task automatic waitDrain(input string name, input int max_cycles);
      logic done;
      done = 1'b0;
      for (int k = 0; k < max_cycles && !done; k++) begin
         @(negedge clock_in);
         done = (exp_q.size() == 0);
         for (int i = 0; i < NUM_REQ; i++) if (src_q[i].size() != 0) done = 1'b0;
      end
      checkOutput(name, 64'(done), 64'd1);
      repeat (3) @(negedge clock_in);
   endtask

   // Producer model: a word leaves its queue only when valid and ready were both high at the edge.
   initial begin
      logic [NUM_REQ-1:0] taken;
      req_valid = '0;
      req_data  = '0;
      req_last  = '0;
      forever begin
         @(negedge clock_in);
         taken = req_valid & req_ready & {NUM_REQ{rst_in_n}};
         @(posedge clock_in); #1;
         for (int i = 0; i < NUM_REQ; i++) begin
            if (taken[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
            if (src_q[i].size() > 0) begin
               if (!req_valid[i]) rise_cyc[i] = cyc;
               req_valid[i]                   = 1'b1;
               req_data[i*DATA_WIDTH +: DATA_WIDTH] = src_q[i][0].data;
               req_last[i]                    = src_q[i][0].last;
            end else begin
               req_valid[i] = 1'b0;
               req_last[i]  = 1'b0;
            end
         end
      end
   end

   // Scoreboard monitor: every fifo write must match the head of the expected queue.
   always @(negedge clock_in) begin
      if (rst_in_n && data_in_valid && !data_in_full) begin
         write_count++;
         stamps.push_back(cyc);
         if (exp_q.size() == 0) begin
            checks++;
            $display("[TB] FAIL unexpected_write: got 0x%0h, expected no write", data_in);
         end else begin
            checkOutput("scoreboard_word", 64'(data_in), 64'(exp_q.pop_front()));
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      word_t w;
      logic [DATA_WIDTH-1:0] held;
      logic ok;
      int base;

      rst_in_n     = 1'b0;
      data_in_full = 1'b0;
      #12;
      checkOutput("reset_data_in", 64'(data_in), 64'd0);
      checkOutput("reset_valid", 64'(data_in_valid), 64'd0);
      checkOutput("reset_ready", 64'(req_ready), 64'd0);
      checkOutput("reset_grant_active", 64'(grant_active), 64'd0);
      checkOutput("reset_grant_id", 64'(grant_id), 64'd3);
      @(negedge clock_in);
      rst_in_n = 1'b1;

      $display("[TB] single requester packet");
      stamps.delete();
      for (int s = 0; s < 3; s++) begin
         w.data = DATA_WIDTH'(32'h11 + s);
         w.last = (s == 2);
         src_q[0].push_back(w);
         exp_q.push_back(w.data);
      end
      waitDrain("t1_drain", 50);
      checkOutput("t1_write_count", 64'(stamps.size()), 64'd3);
      if (stamps.size() >= 3) begin
         checkOutput("t1_latency", 64'(stamps[0] - rise_cyc[0]), 64'd2);
         checkOutput("t1_back_to_back", 64'(stamps[2] - stamps[0]), 64'd2);
      end
      checkOutput("t1_grant_id", 64'(grant_id), 64'd0);
      checkOutput("t1_back_to_arb", 64'(grant_active), 64'd0);

      $display("[TB] all requesters streaming");
      doReset();
      for (int i = 0; i < NUM_REQ; i++) applyStimulus(i, 2, 16, -1);
      for (int r = 0; r < 2; r++)
         for (int i = 0; i < NUM_REQ; i++) expectWords(i, 2, r*8, r*8 + 7);
      waitDrain("t2_drain", 300);
      ok = (stamps.size() >= 40);
      for (int k = 0; k < 40 && ok; k++) if (stamps[k] - stamps[0] != k + k/8) ok = 1'b0;
      checkOutput("t2_burst_gap_pattern", 64'(ok), 64'd1);
      checkOutput("t2_last_grant", 64'(grant_id), 64'd3);

      $display("[TB] backpressure mid burst");
      doReset();
      applyStimulus(0, 3, 10, -1);
      applyStimulus(1, 3, 10, -1);
      expectWords(0, 3, 0, 7);
      expectWords(1, 3, 0, 7);
      expectWords(0, 3, 8, 9);
      expectWords(1, 3, 8, 9);
      base = write_count;
      for (int k = 0; k < 50 && write_count < base + 3; k++) @(negedge clock_in);
      checkOutput("t3_stream_started", 64'(write_count >= base + 3), 64'd1);
      @(posedge clock_in); #2;
      data_in_full = 1'b1;
      @(negedge clock_in);
      held = data_in;
      checkOutput("t3_stall_valid", 64'(data_in_valid), 64'd1);
      checkOutput("t3_stall_ready", 64'(req_ready), 64'd0);
      for (int k = 0; k < 4; k++) begin
         @(negedge clock_in);
         checkOutput("t3_stall_data", 64'(data_in), 64'(held));
         checkOutput("t3_stall_ready", 64'(req_ready), 64'd0);
      end
      @(posedge clock_in); #2;
      data_in_full = 1'b0;
      waitDrain("t3_drain", 200);

      $display("[TB] packet end releases grant");
      doReset();
      applyStimulus(1, 4, 3, 2);
      applyStimulus(2, 4, 5, 4);
      expectWords(1, 4, 0, 2);
      expectWords(2, 4, 0, 4);
      waitDrain("t4_drain", 100);
      checkOutput("t4_grant_id", 64'(grant_id), 64'd2);
      checkOutput("t4_idle", 64'(grant_active), 64'd0);

      $display("[TB] idle requester released");
      doReset();
      applyStimulus(0, 5, 2, -1);
      applyStimulus(1, 5, 10, -1);
      applyStimulus(2, 5, 3, 2);
      expectWords(0, 5, 0, 1);
      expectWords(1, 5, 0, 7);
      expectWords(2, 5, 0, 2);
      expectWords(1, 5, 8, 9);
      waitDrain("t5_drain", 200);
      checkOutput("t5_grant_id", 64'(grant_id), 64'd1);

      $display("[TB] async reset mid burst");
      doReset();
      for (int i = 0; i < NUM_REQ; i++) applyStimulus(i, 6, 12, -1);
      expectWords(0, 6, 0, 7);
      for (int k = 0; k < 50 && !data_in_valid; k++) @(negedge clock_in);
      checkOutput("t6_valid_before_reset", 64'(data_in_valid), 64'd1);
      @(negedge clock_in); #2;
      rst_in_n = 1'b0;
      #1;
      checkOutput("t6_reset_data_in", 64'(data_in), 64'd0);
      checkOutput("t6_reset_valid", 64'(data_in_valid), 64'd0);
      checkOutput("t6_reset_ready", 64'(req_ready), 64'd0);
      checkOutput("t6_reset_grant_active", 64'(grant_active), 64'd0);
      checkOutput("t6_reset_grant_id", 64'(grant_id), 64'd3);
      @(posedge clock_in); #2;
      clearQueues();
      @(posedge clock_in); #2;
      @(negedge clock_in);
      rst_in_n = 1'b1;
      for (int i = 0; i < NUM_REQ; i++) applyStimulus(i, 7, 1, 0);
      for (int i = 0; i < NUM_REQ; i++) expectWords(i, 7, 0, 0);
      waitDrain("t6_drain", 100);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
